// File: rtl/godai_mem_arbiter.sv
// Purpose     : shares one req/gnt/rvalid memory port between the core's instruction
//               and data interfaces, routing responses through an in-order ID FIFO.
// Latency     : request path and response routing are combinational (zero added cycles).
// Backpressure: a request is held locked to its winner until mem_gnt_i. mem_req_o is
//               suppressed while MAX_OUTSTANDING transactions are unanswered.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   instr_req/addr_i              instruction request (always a read)
//   instr_gnt/rvalid/rdata_o      instruction grant and response
//   data_req/we/be/addr/wdata_i   data request
//   data_gnt/rvalid/rdata/err_o   data grant and response (reads and writes)
//   mem_req/we/be/addr/wdata_o    shared memory request
//   mem_gnt/rvalid/rdata/err_i    shared memory grant and response
//   outstanding_o                 current ID FIFO occupancy
//   protocol_err_o                sticky: response arrived with no transaction pending
//
// Configuration
//   GODAI_ARB_ROUND_ROBIN_EN  defined   : round-robin between the two requesters
//                             undefined : fixed priority, DATA beats INSTR
module godai_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  instr_rdata_o,

    input  logic                                   data_req_i,
    input  logic                                   data_we_i,
    input  logic [DATA_WIDTH/8-1:0]                data_be_i,
    input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
    input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  data_rdata_o,
    output logic                                   data_err_o,

    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic                                   mem_err_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   protocol_err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    // A depth-1 FIFO still needs a 1-bit pointer to keep the declarations legal.
    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic                REQ_INSTR = 1'b0;
    localparam logic                REQ_DATA  = 1'b1;

    localparam logic [0:0]          ST_UNLOCKED = 1'b0;
    localparam logic [0:0]          ST_LOCKED   = 1'b1;

    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               id_fifo_q [MAX_OUTSTANDING];
    logic               perr_q, perr_d;
`ifdef GODAI_ARB_ROUND_ROBIN_EN
    // Requester that wins the next tie; flips away from whoever was just granted.
    logic               rr_q, rr_d;
`endif

    logic               any_req;
    logic               full;
    logic               empty;
    logic               pref;
    logic               sel;
    logic               push;
    logic               pop;
    logic               head;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign any_req = instr_req_i | data_req_i;
    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);

    always_comb begin
`ifdef GODAI_ARB_ROUND_ROBIN_EN
        pref = rr_q;
`else
        pref = REQ_DATA;
`endif
        if (state_q == ST_LOCKED) begin
            // A stalled request must keep presenting the same address/data to
            // the memory until it is granted, so the winner is frozen.
            sel = owner_q;
        end else if (instr_req_i && data_req_i) begin
            sel = pref;
        end else if (instr_req_i) begin
            sel = REQ_INSTR;
        end else if (data_req_i) begin
            sel = REQ_DATA;
        end else begin
            sel = pref;
        end
    end

    // Outputs are forced low while reset is held, even though they are
    // otherwise pure functions of the inputs.
    assign mem_req_o   = any_req & ~full & ~rst;
    assign mem_we_o    = (sel == REQ_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (sel == REQ_DATA) ? data_be_i    : {BE_WIDTH{1'b1}};
    assign mem_addr_o  = (sel == REQ_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = (sel == REQ_DATA) ? data_wdata_i : '0;

    assign push        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = push & (sel == REQ_INSTR);
    assign data_gnt_o  = push & (sel == REQ_DATA);

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // FIFO is always empty during reset, so no extra gating is needed here.
    assign head           = id_fifo_q[rd_ptr_q];
    assign pop            = mem_rvalid_i & ~empty;

    assign instr_rvalid_o = pop & (head == REQ_INSTR);
    assign data_rvalid_o  = pop & (head == REQ_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    // The instruction side has no error return, so its errors are dropped.
    assign data_err_o     = data_rvalid_o & mem_err_i;

    assign outstanding_o  = count_q;
    assign protocol_err_o = perr_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (state_q == ST_UNLOCKED) begin
            if (mem_req_o && !mem_gnt_i) begin
                state_d = ST_LOCKED;
                owner_d = sel;
            end
        end else begin
            // Stays locked even if the owner drops its request; that is a
            // requester bug and releasing would corrupt the memory handshake.
            if (mem_gnt_i) begin
                state_d = ST_UNLOCKED;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign perr_d = perr_q | (mem_rvalid_i & empty);

`ifdef GODAI_ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_d = rr_q;
        if (push) begin
            rr_d = ~sel;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_UNLOCKED;
            owner_q  <= REQ_DATA;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            perr_q   <= 1'b0;
`ifdef GODAI_ARB_ROUND_ROBIN_EN
            rr_q     <= REQ_DATA;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            perr_q   <= perr_d;
`ifdef GODAI_ARB_ROUND_ROBIN_EN
            rr_q     <= rr_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo_q[i] <= REQ_DATA;
            end
        end else if (push) begin
            id_fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_godai_mem_arbiter.sv
module tb_godai_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic        mem_err_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  outstanding_o;
    logic        protocol_err_o;

    int checks = 0;
    int errors = 0;

    godai_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_err_i      (mem_err_i),
        .mem_rdata_i    (mem_rdata_i),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        instr_req_i  = 1'b1;
        data_req_i   = 1'b1;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0b want 0", mem_req_o); end
        checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_instr_gnt: got %0b want 0", instr_gnt_o); end
        checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_data_gnt: got %0b want 0", data_gnt_o); end
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rst_outstanding: got %0d want 0", outstanding_o); end
        checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL rst_perr: got %0b want 0", protocol_err_o); end
        clear_inputs();
        #2;
        rst = 1'b0;
        tick();
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rst_release_outstanding: got %0d want 0", outstanding_o); end
        checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL rst_release_perr: got %0b want 0", protocol_err_o); end
    endtask

    task automatic test_single_read();
        clear_inputs();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h20;
        mem_gnt_i    = 1'b1;
        #2;
        checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_instr_gnt: got %0b want 1", instr_gnt_o); end
        checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL rd_data_gnt: got %0b want 0", data_gnt_o); end
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rd_mem_req: got %0b want 1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h20) begin errors++; $display("FAIL rd_mem_addr: got %h want 00000020", mem_addr_o); end
        checks++; if ({mem_we_o, mem_be_o} !== 5'b0_1111) begin errors++; $display("FAIL rd_we_be: got %b want 01111", {mem_we_o, mem_be_o}); end
        checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL rd_wdata: got %h want 00000000", mem_wdata_o); end
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rd_outstanding0: got %0d want 0", outstanding_o); end
        tick();
        clear_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00000013;
        #2;
        checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL rd_outstanding1: got %0d want 1", outstanding_o); end
        checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_instr_rvalid: got %0b want 1", instr_rvalid_o); end
        checks++; if (instr_rdata_o !== 32'h00000013) begin errors++; $display("FAIL rd_instr_rdata: got %h want 00000013", instr_rdata_o); end
        checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_data_rvalid: got %0b want 0", data_rvalid_o); end
        tick();
        clear_inputs();
        #2;
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rd_outstanding2: got %0d want 0", outstanding_o); end
        checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_instr_rvalid_idle: got %0b want 0", instr_rvalid_o); end
    endtask

    // Instr stalls alone first; data joining later must not steal the port.
    task automatic test_lock_hold();
        clear_inputs();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        #2;
        checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL lock_addr0: got %h want 00000100", mem_addr_o); end
        checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL lock_gnt0: got %0b want 0", instr_gnt_o); end
        tick();
        for (int c = 1; c < 4; c++) begin
            data_req_i   = 1'b1;
            data_we_i    = 1'b1;
            data_be_i    = 4'b0011;
            data_addr_i  = 32'h200;
            data_wdata_i = 32'hDEADBEEF;
            mem_gnt_i    = (c == 3);
            #2;
            checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL lock_addr%0d: got %h want 00000100", c, mem_addr_o); end
            checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL lock_we%0d: got %0b want 0", c, mem_we_o); end
            checks++; if (instr_gnt_o !== (c == 3)) begin errors++; $display("FAIL lock_instr_gnt%0d: got %0b want %0b", c, instr_gnt_o, (c == 3)); end
            checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL lock_data_gnt%0d: got %0b want 0", c, data_gnt_o); end
            tick();
        end
        checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL lock_outstanding: got %0d want 1", outstanding_o); end
        // Lock released; data wins next (fixed priority, or RR pointer now at DATA).
        mem_gnt_i = 1'b1;
        #2;
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL unlock_data_gnt: got %0b want 1", data_gnt_o); end
        checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL unlock_instr_gnt: got %0b want 0", instr_gnt_o); end
        checks++; if (mem_addr_o !== 32'h200) begin errors++; $display("FAIL unlock_addr: got %h want 00000200", mem_addr_o); end
        checks++; if ({mem_we_o, mem_be_o} !== 5'b1_0011) begin errors++; $display("FAIL unlock_we_be: got %b want 10011", {mem_we_o, mem_be_o}); end
        checks++; if (mem_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL unlock_wdata: got %h want deadbeef", mem_wdata_o); end
        tick();
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL unlock_outstanding: got %0d want 2", outstanding_o); end
    endtask

    // FIFO holds {I, D}; exercise full, in-order routing and push+pop.
    task automatic test_full_and_routing();
        logic win_d;
`ifdef GODAI_ARB_ROUND_ROBIN_EN
        win_d = 1'b0;
`else
        win_d = 1'b1;
`endif
        mem_gnt_i = 1'b1;
        #2;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL full_mem_req: got %0b want 0", mem_req_o); end
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin errors++; $display("FAIL full_gnt: got %b want 00", {instr_gnt_o, data_gnt_o}); end
        tick();
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL full_outstanding: got %0d want 2", outstanding_o); end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hA;
        mem_err_i    = 1'b1;
        #2;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL full_pop_mem_req: got %0b want 0", mem_req_o); end
        checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL resp1_instr_rvalid: got %0b want 1", instr_rvalid_o); end
        checks++; if (instr_rdata_o !== 32'hA) begin errors++; $display("FAIL resp1_instr_rdata: got %h want 0000000a", instr_rdata_o); end
        checks++; if ({data_rvalid_o, data_err_o} !== 2'b00) begin errors++; $display("FAIL resp1_data: got %b want 00", {data_rvalid_o, data_err_o}); end
        tick();
        checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL resp1_outstanding: got %0d want 1", outstanding_o); end
        mem_rdata_i = 32'hB;
        #2;
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL freed_mem_req: got %0b want 1", mem_req_o); end
        checks++; if (data_gnt_o !== win_d) begin errors++; $display("FAIL freed_data_gnt: got %0b want %0b", data_gnt_o, win_d); end
        checks++; if (instr_gnt_o !== !win_d) begin errors++; $display("FAIL freed_instr_gnt: got %0b want %0b", instr_gnt_o, !win_d); end
        checks++; if (data_rvalid_o !== 1'b1) begin errors++; $display("FAIL resp2_data_rvalid: got %0b want 1", data_rvalid_o); end
        checks++; if (data_rdata_o !== 32'hB) begin errors++; $display("FAIL resp2_data_rdata: got %h want 0000000b", data_rdata_o); end
        checks++; if (data_err_o !== 1'b1) begin errors++; $display("FAIL resp2_data_err: got %0b want 1", data_err_o); end
        checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL resp2_instr_rvalid: got %0b want 0", instr_rvalid_o); end
        tick();
        checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL pushpop_outstanding: got %0d want 1", outstanding_o); end
        clear_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hC;
        #2;
        checks++; if (data_rvalid_o !== win_d) begin errors++; $display("FAIL resp3_data_rvalid: got %0b want %0b", data_rvalid_o, win_d); end
        checks++; if (instr_rvalid_o !== !win_d) begin errors++; $display("FAIL resp3_instr_rvalid: got %0b want %0b", instr_rvalid_o, !win_d); end
        checks++; if (data_err_o !== 1'b0) begin errors++; $display("FAIL resp3_data_err: got %0b want 0", data_err_o); end
        tick();
        clear_inputs();
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL resp3_outstanding: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_back_to_back();
        logic exp_d [4];
`ifdef GODAI_ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            instr_req_i  = (k < 4);
            instr_addr_i = 32'h1000 + k;
            data_req_i   = (k < 4);
            data_addr_i  = 32'h2000 + k;
            mem_gnt_i    = (k < 4);
            mem_rvalid_i = (k > 0);
            mem_rdata_i  = k;
            #2;
            if (k < 4) begin
                checks++; if (data_gnt_o !== exp_d[k]) begin errors++; $display("FAIL b2b_data_gnt%0d: got %0b want %0b", k, data_gnt_o, exp_d[k]); end
                checks++; if (instr_gnt_o !== !exp_d[k]) begin errors++; $display("FAIL b2b_instr_gnt%0d: got %0b want %0b", k, instr_gnt_o, !exp_d[k]); end
            end
            if (k > 0) begin
                checks++; if (data_rvalid_o !== exp_d[k-1]) begin errors++; $display("FAIL b2b_data_rvalid%0d: got %0b want %0b", k, data_rvalid_o, exp_d[k-1]); end
                checks++; if (instr_rvalid_o !== !exp_d[k-1]) begin errors++; $display("FAIL b2b_instr_rvalid%0d: got %0b want %0b", k, instr_rvalid_o, !exp_d[k-1]); end
            end
            tick();
        end
        clear_inputs();
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL b2b_outstanding: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_protocol_err();
        clear_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h55;
        mem_err_i    = 1'b1;
        #2;
        checks++; if ({instr_rvalid_o, data_rvalid_o, data_err_o} !== 3'b000) begin errors++; $display("FAIL perr_outputs: got %b want 000", {instr_rvalid_o, data_rvalid_o, data_err_o}); end
        tick();
        clear_inputs();
        checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL perr_set: got %0b want 1", protocol_err_o); end
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL perr_outstanding: got %0d want 0", outstanding_o); end
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h40;
        mem_gnt_i    = 1'b1;
        #2;
        checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL perr_instr_gnt: got %0b want 1", instr_gnt_o); end
        tick();
        clear_inputs();
        checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0b want 1", protocol_err_o); end
        checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL perr_outstanding1: got %0d want 1", outstanding_o); end
    endtask

    task automatic test_reset_mid_lock();
        clear_inputs();
        data_req_i  = 1'b1;
        data_addr_i = 32'h300;
        #2;
        checks++; if (mem_addr_o !== 32'h300) begin errors++; $display("FAIL rml_addr0: got %h want 00000300", mem_addr_o); end
        tick();
        // Owner drops its request; the lock must still hold the data address.
        clear_inputs();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        data_addr_i  = 32'h300;
        #2;
        checks++; if (mem_addr_o !== 32'h300) begin errors++; $display("FAIL rml_locked_addr: got %h want 00000300", mem_addr_o); end
        rst = 1'b1;
        #1;
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rml_outstanding: got %0d want 0", outstanding_o); end
        checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL rml_perr: got %0b want 0", protocol_err_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rml_mem_req: got %0b want 0", mem_req_o); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (mem_addr_o !== 32'h80) begin errors++; $display("FAIL rml_unlocked_addr: got %h want 00000080", mem_addr_o); end
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rml_mem_req_after: got %0b want 1", mem_req_o); end
        clear_inputs();
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77;
        #2;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rml_late_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        clear_inputs();
        checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL rml_late_perr: got %0b want 1", protocol_err_o); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_lock_hold();
        test_full_and_routing();
        test_back_to_back();
        test_protocol_err();
        test_reset_mid_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
